sevseg_mux_driver: RTL
======================

SEVSEG_MUX_DRIVER -- requirements
Module: sevseg_mux_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (>= 4).
REQ-003 SHALL have parameter BLANK_CYCLES, default 500, anode-off cycles at the start of each slot (1..REFRESH_DIV-1).
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1, segment/dp polarity (1 = low lights).
REQ-005 SHALL have parameter AN_ACTIVE_LOW, default 1, anode polarity (1 = low enables).
REQ-006 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1, scan enable.
REQ-009 SHALL have port load, input, 1, one-cycle strobe capturing value and dp_in.
REQ-010 SHALL have port value, input, 4*NUM_DIGITS, hex nibbles; nibble 0 = rightmost digit.
REQ-011 SHALL have port dp_in, input, NUM_DIGITS, decimal point per digit.
REQ-012 SHALL have port lz_blank, input, 1, leading-zero suppression enable.
REQ-013 SHALL have port segments, output, 7, registered pattern, bit6=g .. bit0=a.
REQ-014 SHALL have port dp, output, 1, registered decimal point.
REQ-015 SHALL have port anodes, output, NUM_DIGITS, registered one-hot (or all-off) digit enables.
REQ-016 SHALL have port frame_tick, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-017 Slot counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit index SHALL advance, wrapping NUM_DIGITS-1 -> 0.
REQ-018 FSM states: BLANK (slot count < BLANK_CYCLES; all anodes inactive; segments/dp off) and DRIVE (own anode active; segments/dp for that digit).
REQ-019 Outputs SHALL be registered; segments, dp and anode for a digit change on the same edge (no skew).
REQ-020 Hex encoding (active-low, hex per digit 0..F): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E; inverted when SEG_ACTIVE_LOW=0.
REQ-021 load SHALL write value/dp_in into a pending register and set pending flag; a later load before transfer overwrites (last wins).
REQ-022 Pending contents SHALL transfer to the display register on the edge where digit index wraps to 0 (frame boundary), clearing pending; no mid-frame tearing.
REQ-023 load coincident with the boundary edge SHALL write the incoming value directly to the display register and leave pending clear.
REQ-024 frame_tick SHALL be high for exactly the cycle following each boundary edge.
REQ-025 With lz_blank=1, contiguous zero nibbles from the most significant digit downward SHALL be blanked (segments and dp off, anode still driven), digit 0 never blanked; evaluated on the display register.
REQ-026 enable=0 SHALL force anodes inactive, segments/dp off, clear counters/index to 0, state BLANK, and transfer any pending value immediately; no frame_tick.
REQ-027 enable rising SHALL restart at digit 0, slot count 0, in BLANK.

Reset
REQ-028 rst SHALL asynchronously set: anodes inactive, segments and dp off (polarity-aware), frame_tick 0, slot count 0, digit index 0, state BLANK, display and pending registers 0, pending flag 0.
REQ-029 rst asserted mid-frame or mid-load SHALL discard pending data; first DRIVE after release is digit 0 showing 0.

Structure
REQ-030 Shared package sevseg_pkg SHALL hold the hex-to-segment table/function, FSM state typedef, and segment-off constant.
REQ-031 One sub-module sevseg_decode (combinational nibble -> 7-bit active-low pattern) SHALL be instantiated once on the selected nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, active-low)
REQ-032 Reset release, enable=1 -> anodes 1111 two cycles, then 1110 with segments 40 for six cycles; frame_tick every 32 cycles.
REQ-033 load value=16'h12AF mid-frame -> unchanged until next boundary; then digits 0..3 show 0E,08,24,79.
REQ-034 Two loads 16'h1111 then 16'h2222 in one frame -> only 2222 (pattern 24) displayed; load on boundary edge -> shown that frame.
REQ-035 lz_blank=1, value 16'h0050 -> digits 3,2 segments 7F with anodes still cycling; digit 1 = 12, digit 0 = 40; value 0 -> digit 0 shows 40.
REQ-036 enable dropped for 5 cycles mid-DRIVE -> anodes 1111 next edge; re-enable restarts at digit 0 BLANK; rst asserted mid-DRIVE -> outputs off asynchronously.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment patterns are active-low with bit6=g .. bit0=a.
package sevseg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF_LOW = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      4'hF:    hex_to_seg = 7'h0E;
      default: hex_to_seg = SEG_OFF_LOW;
    endcase
  endfunction

endpackage

// File: rtl/sevseg_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = hex_to_seg(nibble);

endmodule

// File: rtl/sevseg_mux_driver.sv
// Time-multiplexed hex display driver with frame-synchronous updates,
// per-slot anode blanking and optional leading-zero suppression.
module sevseg_mux_driver
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_LOW : ~SEG_OFF_LOW;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CW-1:0]           cnt_r, cnt_next_s;
  logic [DW-1:0]           digit_r, digit_next_s;
  logic                    boundary_s, drive_s;
  state_t                  state_r;
  logic [4*NUM_DIGITS-1:0] disp_val_r, disp_val_next_s, pend_val_r, pend_val_next_s;
  logic [NUM_DIGITS-1:0]   disp_dp_r, disp_dp_next_s, pend_dp_r, pend_dp_next_s;
  logic                    pend_flag_r, pend_flag_next_s;
  logic [NUM_DIGITS-1:0]   blank_s, onehot_s, an_drive_s;
  logic [3:0]              nibble_s;
  logic [6:0]              pattern_s, seg_drive_s;
  logic                    dim_s, dp_drive_s;

  // Slot/digit position for the next cycle and frame boundary detection
  always_comb begin
    cnt_next_s   = cnt_r;
    digit_next_s = digit_r;
    boundary_s   = 1'b0;
    if (!enable) begin
      cnt_next_s   = {CW{1'b0}};
      digit_next_s = {DW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_next_s = {CW{1'b0}};
      if (digit_r == DIG_LAST) begin
        digit_next_s = {DW{1'b0}};
        boundary_s   = 1'b1;
      end else begin
        digit_next_s = digit_r + 1'b1;
      end
    end else begin
      cnt_next_s = cnt_r + 1'b1;
    end
  end

  // Display/pending update: transfers only at frame boundary or while disabled
  always_comb begin
    disp_val_next_s  = disp_val_r;
    disp_dp_next_s   = disp_dp_r;
    pend_val_next_s  = pend_val_r;
    pend_dp_next_s   = pend_dp_r;
    pend_flag_next_s = pend_flag_r;
    if (!enable || boundary_s) begin
      pend_flag_next_s = 1'b0;
      if (load) begin
        disp_val_next_s = value;
        disp_dp_next_s  = dp_in;
      end else if (pend_flag_r) begin
        disp_val_next_s = pend_val_r;
        disp_dp_next_s  = pend_dp_r;
      end else begin
        disp_val_next_s = disp_val_r;
        disp_dp_next_s  = disp_dp_r;
      end
    end else if (load) begin
      pend_val_next_s  = value;
      pend_dp_next_s   = dp_in;
      pend_flag_next_s = 1'b1;
    end else begin
      pend_flag_next_s = pend_flag_r;
    end
  end

  // Output pattern for the digit that will be shown after this edge
  always_comb begin
    logic run;
    run     = 1'b1;
    blank_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run        = run & (disp_val_next_s[4*i +: 4] == 4'h0);
      blank_s[i] = lz_blank & run & (i != 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot_s[i] = (digit_next_s == DW'(i));
    end
    nibble_s    = disp_val_next_s[{digit_next_s, 2'b00} +: 4];
    dim_s       = blank_s[digit_next_s];
    seg_drive_s = dim_s ? SEG_OFF : (pattern_s ^ ~SEG_OFF);
    dp_drive_s  = dim_s ? DP_OFF : (disp_dp_next_s[digit_next_s] ^ DP_OFF);
    an_drive_s  = onehot_s ^ AN_OFF;
    drive_s     = (cnt_next_s >= CNT_BLANK);
  end

  sevseg_decode u_decode (
    .nibble  (nibble_s),
    .pattern (pattern_s)
  );

  // Position counters, BLANK/DRIVE FSM, data registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      digit_r     <= {DW{1'b0}};
      state_r     <= ST_BLANK;
      disp_val_r  <= {(4*NUM_DIGITS){1'b0}};
      disp_dp_r   <= {NUM_DIGITS{1'b0}};
      pend_val_r  <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r   <= {NUM_DIGITS{1'b0}};
      pend_flag_r <= 1'b0;
      segments    <= SEG_OFF;
      dp          <= DP_OFF;
      anodes      <= AN_OFF;
      frame_tick  <= 1'b0;
    end else begin
      cnt_r       <= cnt_next_s;
      digit_r     <= digit_next_s;
      disp_val_r  <= disp_val_next_s;
      disp_dp_r   <= disp_dp_next_s;
      pend_val_r  <= pend_val_next_s;
      pend_dp_r   <= pend_dp_next_s;
      pend_flag_r <= pend_flag_next_s;
      frame_tick  <= boundary_s;
      case (state_r)
        ST_BLANK: state_r <= drive_s ? ST_DRIVE : ST_BLANK;
        ST_DRIVE: state_r <= drive_s ? ST_DRIVE : ST_BLANK;
        default:  state_r <= ST_BLANK;
      endcase
      if (drive_s) begin
        segments <= seg_drive_s;
        dp       <= dp_drive_s;
        anodes   <= an_drive_s;
      end else begin
        segments <= SEG_OFF;
        dp       <= DP_OFF;
        anodes   <= AN_OFF;
      end
    end
  end

endmodule
